cdb_arbiter: RTL and testbench

- Producer end of the common data bus (CDB).
- Collects completed results (tag + 32-bit value) from N functional units: load path, ALU, multiplier, etc.
- Buffers each source in a small per-source FIFO and grants one result per cycle round-robin.
- Drives the registered cdb_valid/cdb_tag/cdb_data broadcast consumed by reservation stations, the register status table and the load/store address unit.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source result FIFOs, round-robin grant of one
// result per cycle into a registered cdb_valid/cdb_tag/cdb_data broadcast.
module cdb_arbiter #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [N_SRC-1:0]           src_valid,
   input  logic [N_SRC*TAG_W-1:0]     src_tag,
   input  logic [N_SRC*32-1:0]        src_data,
   output logic [N_SRC-1:0]           src_ready,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [31:0]                cdb_data,
   output logic [$clog2(N_SRC)-1:0]   cdb_src,
   output logic                       tag_err
);

   localparam int unsigned SW = $clog2(N_SRC);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = TAG_W + 32;

   logic [EW-1:0]      mem_q [N_SRC][DEPTH];
   logic [EW-1:0]      mem_d [N_SRC][DEPTH];
   logic [PW-1:0]      wr_q  [N_SRC];
   logic [PW-1:0]      wr_d  [N_SRC];
   logic [PW-1:0]      rd_q  [N_SRC];
   logic [PW-1:0]      rd_d  [N_SRC];

   logic [N_SRC-1:0]   full;
   logic [N_SRC-1:0]   empty;
   logic [N_SRC-1:0]   push;
   logic [N_SRC-1:0]   zero_tag;

   logic [SW-1:0]      rr_q, rr_d;
   logic [SW-1:0]      win;
   logic               win_vld;
   logic               grant;

   logic               cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
   logic [31:0]        cdb_data_q, cdb_data_d;
   logic [SW-1:0]      cdb_src_q, cdb_src_d;
   logic               tag_err_q, tag_err_d;

   // Ready depends only on registered pointers, never on this cycle's grant.
   always_comb begin
      full     = '0;
      empty    = '0;
      push     = '0;
      zero_tag = '0;
      for (int i = 0; i < N_SRC; i++) begin
         empty[i]    = (wr_q[i] == rd_q[i]);
         full[i]     = (wr_q[i][PW-1] != rd_q[i][PW-1]) &&
                       (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
         zero_tag[i] = (src_tag[i*TAG_W +: TAG_W] == '0);
         push[i]     = src_valid[i] && !full[i] && !zero_tag[i] && !flush;
      end
   end

   assign src_ready = ~full;

   // Scan offsets from N_SRC down to 1 so the smallest offset after rr_q wins.
   always_comb begin
      int unsigned idx;
      logic [SW-1:0] cand;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         idx  = (int'(rr_q) + k) % N_SRC;
         cand = idx[SW-1:0];
         if (!empty[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   assign grant = win_vld && !flush;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (flush) begin
            wr_d[i] = '0;
            rd_d[i] = '0;
         end else begin
            if (push[i]) begin
               mem_d[i][wr_q[i][AW-1:0]] = {src_tag[i*TAG_W +: TAG_W], src_data[i*32 +: 32]};
               wr_d[i] = wr_q[i] + PW'(1);
            end
            if (grant && (win == SW'(i))) begin
               rd_d[i] = rd_q[i] + PW'(1);
            end
         end
      end
   end

   always_comb begin
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      rr_d        = rr_q;
      tag_err_d   = tag_err_q | (|(src_valid & zero_tag));
      if (grant) begin
         cdb_valid_d = 1'b1;
         {cdb_tag_d, cdb_data_d} = mem_q[win][rd_q[win][AW-1:0]];
         cdb_src_d   = win;
         rr_d        = win;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SRC; i++) begin
            wr_q[i] <= '0;
            rd_q[i] <= '0;
         end
         rr_q        <= SW'(N_SRC - 1);
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
         tag_err_q   <= 1'b0;
      end else begin
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rr_q        <= rr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
         tag_err_q   <= tag_err_d;
      end
   end

   // Payload storage needs no reset; validity lives in the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;
   assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: cycle-by-cycle vector table plus hand-written
// reset and backpressure sequences.
module tb_cdb_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [3:0]    src_valid;
   logic [15:0]   src_tag;
   logic [127:0]  src_data;
   logic [3:0]    src_ready;
   logic          cdb_valid;
   logic [3:0]    cdb_tag;
   logic [31:0]   cdb_data;
   logic [1:0]    cdb_src;
   logic          tag_err;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_arbiter #(.N_SRC(4), .DEPTH(2), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src),
      .tag_err   (tag_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   v;
      logic [15:0]  tag;
      logic [127:0] data;
      logic         fl;
      logic         ev;
      logic [3:0]   et;
      logic [31:0]  ed;
      logic [1:0]   es;
      logic [3:0]   er;
      logic         ee;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] lanes(input logic [15:0] t);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = 32'hC0DE_0000 | {28'h0, t[i*4 +: 4]};
      return r;
   endfunction

   task automatic add(input logic [3:0] v, input logic [15:0] t, input logic [127:0] d,
                      input logic fl, input logic ev, input logic [3:0] et,
                      input logic [31:0] ed, input logic [1:0] es, input logic [3:0] er,
                      input logic ee);
      vec_t x;
      x.v = v; x.tag = t; x.data = d; x.fl = fl; x.ev = ev; x.et = et;
      x.ed = ed; x.es = es; x.er = er; x.ee = ee;
      vecs.push_back(x);
   endtask

   task automatic idle_in();
      src_valid = '0;
      src_tag   = '0;
      src_data  = '0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int   next0, exp0, k1, prev_src;
      logic acc0, acc1, saw_full0;
      logic [3:0] t1;
      logic [3:0] q1[$];

      // Round robin from reset (rr=3), then again with last grant = 1.
      add(4'b1111, 16'h4321, lanes(16'h4321), 0, 0, 4'h0, 32'h0,         2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h1, 32'hC0DE_0001, 2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h2, 32'hC0DE_0002, 2'd1, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h3, 32'hC0DE_0003, 2'd2, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h4, 32'hC0DE_0004, 2'd3, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'h4, 32'hC0DE_0004, 2'd3, 4'hF, 0);
      add(4'b0010, 16'h0090, lanes(16'h0090), 0, 0, 4'h4, 32'hC0DE_0004, 2'd3, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h9, 32'hC0DE_0009, 2'd1, 4'hF, 0);
      add(4'b1111, 16'hDCBA, lanes(16'hDCBA), 0, 0, 4'h9, 32'hC0DE_0009, 2'd1, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'hC, 32'hC0DE_000C, 2'd2, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'hD, 32'hC0DE_000D, 2'd3, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'hA, 32'hC0DE_000A, 2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'hB, 32'hC0DE_000B, 2'd1, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'hB, 32'hC0DE_000B, 2'd1, 4'hF, 0);
      // Single result from source 2.
      add(4'b0100, 16'h0500, {32'h0, 32'hDEAD_BEEF, 64'h0},
                                              0, 0, 4'hB, 32'hC0DE_000B, 2'd1, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h5, 32'hDEAD_BEEF, 2'd2, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'h5, 32'hDEAD_BEEF, 2'd2, 4'hF, 0);
      // Fill three sources, flush (with a discarded push), then new traffic.
      add(4'b0111, 16'h0321, lanes(16'h0321), 0, 0, 4'h5, 32'hDEAD_BEEF, 2'd2, 4'hF, 0);
      add(4'b0111, 16'h0654, lanes(16'h0654), 0, 1, 4'h1, 32'hC0DE_0001, 2'd0, 4'b1001, 0);
      add(4'b0001, 16'h0007, lanes(16'h0007), 1, 0, 4'h1, 32'hC0DE_0001, 2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'h1, 32'hC0DE_0001, 2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'h1, 32'hC0DE_0001, 2'd0, 4'hF, 0);
      add(4'b0010, 16'h0070, lanes(16'h0070), 0, 0, 4'h1, 32'hC0DE_0001, 2'd0, 4'hF, 0);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'h7, 32'hC0DE_0007, 2'd1, 4'hF, 0);
      // Zero tag: no broadcast, sticky error through later traffic.
      add(4'b1000, 16'h0000, {32'h1234_5678, 96'h0},
                                              0, 0, 4'h7, 32'hC0DE_0007, 2'd1, 4'hF, 1);
      add(4'b0000, 16'h0,    128'h0,          0, 0, 4'h7, 32'hC0DE_0007, 2'd1, 4'hF, 1);
      add(4'b1000, 16'hE000, lanes(16'hE000), 0, 0, 4'h7, 32'hC0DE_0007, 2'd1, 4'hF, 1);
      add(4'b0000, 16'h0,    128'h0,          0, 1, 4'hE, 32'hC0DE_000E, 2'd3, 4'hF, 1);

      idle_in();
      rst_n = 1'b0;
      #1;
      chk("reset_valid", 32'(cdb_valid), 32'h0);
      chk("reset_ready", 32'(src_ready), 32'hF);
      chk("reset_err",   32'(tag_err),   32'h0);
      chk("reset_tag",   32'(cdb_tag),   32'h0);
      chk("reset_src",   32'(cdb_src),   32'h0);
      do_reset();

      foreach (vecs[n]) begin
         src_valid = vecs[n].v;
         src_tag   = vecs[n].tag;
         src_data  = vecs[n].data;
         flush     = vecs[n].fl;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", n), 32'(cdb_valid), 32'(vecs[n].ev));
         chk($sformatf("vec%0d_tag",   n), 32'(cdb_tag),   32'(vecs[n].et));
         chk($sformatf("vec%0d_data",  n), cdb_data,       vecs[n].ed);
         chk($sformatf("vec%0d_src",   n), 32'(cdb_src),   32'(vecs[n].es));
         chk($sformatf("vec%0d_ready", n), 32'(src_ready), 32'(vecs[n].er));
         chk($sformatf("vec%0d_err",   n), 32'(tag_err),   32'(vecs[n].ee));
      end

      // Async reset while the last vector's broadcast is on the bus.
      idle_in();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(cdb_valid), 32'h0);
      chk("midrst_ready", 32'(src_ready), 32'hF);
      chk("midrst_err",   32'(tag_err),   32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle%0d_valid", c), 32'(cdb_valid), 32'h0);
      end

      // Backpressure and pointer wrap: src0 streams tags 1..9, src1 always busy.
      do_reset();
      next0 = 1; exp0 = 1; k1 = 0; prev_src = -1; saw_full0 = 1'b0;
      for (int cyc = 0; cyc < 60 && exp0 <= 9; cyc++) begin
         t1        = 4'((k1 % 15) + 1);
         src_valid = {2'b00, 1'b1, (next0 <= 9)};
         src_tag   = {8'h0, t1, 4'(next0)};
         src_data  = {64'h0, 32'hB000_0000 | {28'h0, t1}, 32'hA000_0000 | 32'(next0)};
         acc0      = src_ready[0] && (next0 <= 9);
         acc1      = src_ready[1];
         if (!src_ready[0]) saw_full0 = 1'b1;
         @(posedge clk);
         #1;
         if (acc0) next0++;
         if (acc1) begin
            q1.push_back(t1);
            k1++;
         end
         if (cdb_valid) begin
            chk("bp_alternate", 32'(int'(cdb_src) != prev_src), 32'h1);
            if (cdb_src == 2'd0) begin
               chk("bp_src0_tag",  32'(cdb_tag), 32'(exp0));
               chk("bp_src0_data", cdb_data,     32'hA000_0000 | 32'(exp0));
               exp0++;
            end else if (q1.size() == 0) begin
               chk("bp_src1_unexpected", 32'(cdb_src), 32'h0);
            end else begin
               chk("bp_src1_tag", 32'(cdb_tag), 32'(q1.pop_front()));
            end
            prev_src = int'(cdb_src);
         end
      end
      chk("bp_all_src0_seen", 32'(exp0), 32'd10);
      chk("bp_ready0_dropped", 32'(saw_full0), 32'h1);

      idle_in();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
